// File: rtl/rotation_kick_controller.sv
// Sequences SRS wall-kick tests 0..MAX_STEP for one rotation request through an external kick table
// and a req/ack collision checker. Optional macro ROTATE_CCW_EN enables counter-clockwise requests.

// Piece encoding: 0=I 1=O 2=T 3=S 4=Z 5=J 6=L
typedef logic [2:0] tetromino_idx_t;

module rotation_kick_controller #(
    parameter int POS_W    = 6,
    parameter int MAX_STEP = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    dir,
    input  logic signed [POS_W-1:0] cur_x,
    input  logic signed [POS_W-1:0] cur_y,
    input  logic [1:0]              cur_rotation,
    input  tetromino_idx_t          cur_idx,
    output logic [1:0]              kick_rotation,
    output logic [2:0]              kick_step,
    output tetromino_idx_t          kick_idx,
    input  logic signed [2:0]       kick_add_x,
    input  logic signed [2:0]       kick_add_y,
    output logic                    check_req,
    output logic signed [POS_W-1:0] check_x,
    output logic signed [POS_W-1:0] check_y,
    output logic [1:0]              check_rotation,
    input  logic                    check_ack,
    input  logic                    check_hit,
    output logic                    busy,
    output logic                    done,
    output logic                    success,
    output logic signed [POS_W-1:0] new_x,
    output logic signed [POS_W-1:0] new_y,
    output logic [1:0]              new_rotation,
    output logic [2:0]              kick_used
);

    localparam tetromino_idx_t PIECE_O = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              step, step_nxt;
    logic signed [POS_W-1:0] lat_x, lat_y;
    logic [1:0]              lat_rot;
    tetromino_idx_t          lat_idx;
    logic                    take_start, commit_ok, commit_fail, last_test;
    logic signed [POS_W-1:0] ext_x, ext_y, off_x, off_y;

    function automatic logic signed [POS_W-1:0] sext3(input logic signed [2:0] v);
        return {{(POS_W-3){v[2]}}, v};
    endfunction

    // The O piece never kicks: its single test uses a zero offset whatever the table says.
    always_comb begin
        ext_x = '0;
        ext_y = '0;
        if (lat_idx != PIECE_O) begin
            ext_x = sext3(kick_add_x);
            ext_y = sext3(kick_add_y);
        end
    end

`ifdef ROTATE_CCW_EN
    logic lat_ccw;

    always_ff @(posedge clk) begin
        if (reset)
            lat_ccw <= 1'b0;
        else if (take_start)
            lat_ccw <= dir;
    end

    // CCW r->r-1 reuses the CW (r-1)->r kicks, negated after sign extension.
    always_comb begin
        kick_rotation  = lat_rot;
        check_rotation = lat_rot + 2'd1;
        off_x          = ext_x;
        off_y          = ext_y;
        if (lat_ccw) begin
            kick_rotation  = lat_rot - 2'd1;
            check_rotation = lat_rot - 2'd1;
            off_x          = -ext_x;
            off_y          = -ext_y;
        end
    end
`else
    logic unused_dir;
    assign unused_dir = dir;

    always_comb begin
        kick_rotation  = lat_rot;
        check_rotation = lat_rot + 2'd1;
        off_x          = ext_x;
        off_y          = ext_y;
    end
`endif

    assign check_x   = lat_x + off_x;
    assign check_y   = lat_y + off_y;
    assign kick_step = step;
    assign kick_idx  = lat_idx;
    assign check_req = (state == S_REQ);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign last_test = (step == 3'(MAX_STEP)) || (lat_idx == PIECE_O);

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        take_start  = 1'b0;
        commit_ok   = 1'b0;
        commit_fail = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    step_nxt   = '0;
                    state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                if (check_ack) begin
                    if (!check_hit) begin
                        commit_ok = 1'b1;
                        state_nxt = S_DONE;
                    end else if (last_test) begin
                        commit_fail = 1'b1;
                        state_nxt   = S_DONE;
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            step         <= '0;
            lat_x        <= '0;
            lat_y        <= '0;
            lat_rot      <= '0;
            lat_idx      <= '0;
            new_x        <= '0;
            new_y        <= '0;
            new_rotation <= '0;
            kick_used    <= '0;
            success      <= 1'b0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            if (take_start) begin
                lat_x   <= cur_x;
                lat_y   <= cur_y;
                lat_rot <= cur_rotation;
                lat_idx <= cur_idx;
            end
            if (commit_ok) begin
                new_x        <= check_x;
                new_y        <= check_y;
                new_rotation <= check_rotation;
                kick_used    <= step;
                success      <= 1'b1;
            end else if (commit_fail) begin
                new_x        <= lat_x;
                new_y        <= lat_y;
                new_rotation <= lat_rot;
                kick_used    <= '0;
                success      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rotation_kick_controller.sv
// Randomized bench for rotation_kick_controller: SRS kick table and collision checker are modelled
// here, and a behavioural model predicts every candidate and the final result.
`timescale 1ns/1ps
module tb_rotation_kick_controller;
    localparam int POS_W    = 6;
    localparam int MAX_STEP = 4;
    localparam logic [2:0] P_I = 3'd0, P_O = 3'd1, P_T = 3'd2, P_J = 3'd5;
`ifdef ROTATE_CCW_EN
    localparam bit CCW_EN = 1'b1;
`else
    localparam bit CCW_EN = 1'b0;
`endif

    // Clockwise SRS kicks indexed [from_rotation][test]
    localparam int JX [4][5] = '{'{0,-1,-1, 0,-1}, '{0, 1, 1, 0, 1}, '{0, 1, 1, 0, 1}, '{0,-1,-1, 0,-1}};
    localparam int JY [4][5] = '{'{0, 0, 1,-2,-2}, '{0, 0,-1, 2, 2}, '{0, 0, 1,-2,-2}, '{0, 0,-1, 2, 2}};
    localparam int IX [4][5] = '{'{0,-2, 1,-2, 1}, '{0,-1, 2,-1, 2}, '{0, 2,-1, 2,-1}, '{0, 1,-2, 1,-2}};
    localparam int IY [4][5] = '{'{0, 0, 0,-1, 2}, '{0, 0, 0, 2,-1}, '{0, 0, 0, 1,-2}, '{0, 0, 0,-2, 1}};

    logic                    clk = 1'b0;
    logic                    reset, start, dir;
    logic signed [POS_W-1:0] cur_x, cur_y;
    logic [1:0]              cur_rotation;
    logic [2:0]              cur_idx;
    logic [1:0]              kick_rotation;
    logic [2:0]              kick_step, kick_idx;
    logic signed [2:0]       kick_add_x, kick_add_y;
    logic                    check_req, check_ack, check_hit;
    logic signed [POS_W-1:0] check_x, check_y;
    logic [1:0]              check_rotation;
    logic                    busy, done, success;
    logic signed [POS_W-1:0] new_x, new_y;
    logic [1:0]              new_rotation;
    logic [2:0]              kick_used;

    int checks = 0;
    int errors = 0;
    int tbl_x, tbl_y;

    logic [2:0]              m_idx;
    logic signed [POS_W-1:0] m_x, m_y;
    logic [1:0]              m_rot;
    logic                    m_ccw;
    int                      req_i;
    logic signed [POS_W-1:0] obs_x[$];
    logic [1:0]              obs_kr[$];

    rotation_kick_controller #(.POS_W(POS_W), .MAX_STEP(MAX_STEP)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir),
        .cur_x(cur_x), .cur_y(cur_y), .cur_rotation(cur_rotation), .cur_idx(cur_idx),
        .kick_rotation(kick_rotation), .kick_step(kick_step), .kick_idx(kick_idx),
        .kick_add_x(kick_add_x), .kick_add_y(kick_add_y),
        .check_req(check_req), .check_x(check_x), .check_y(check_y),
        .check_rotation(check_rotation), .check_ack(check_ack), .check_hit(check_hit),
        .busy(busy), .done(done), .success(success),
        .new_x(new_x), .new_y(new_y), .new_rotation(new_rotation), .kick_used(kick_used)
    );

    always #5 clk = ~clk;

    function automatic void srs_lookup(input logic [2:0] idx, input logic [1:0] r, input int st,
                                       output int kx, output int ky);
        kx = 0;
        ky = 0;
        if (st >= 0 && st <= 4 && idx != P_O) begin
            if (idx == P_I) begin
                kx = IX[r][st];
                ky = IY[r][st];
            end else begin
                kx = JX[r][st];
                ky = JY[r][st];
            end
        end
    endfunction

    always_comb begin
        tbl_x = 0;
        tbl_y = 0;
        srs_lookup(kick_idx, kick_rotation, int'(kick_step), tbl_x, tbl_y);
        kick_add_x = 3'(tbl_x);
        kick_add_y = 3'(tbl_y);
    end

    // Candidate for test i of the current request, straight from the SRS rules.
    function automatic void model_cand(input int i, output logic signed [POS_W-1:0] cx,
                                       output logic signed [POS_W-1:0] cy,
                                       output logic [1:0] kr, output logic [1:0] tr);
        int kx, ky;
        kr = m_ccw ? m_rot - 2'd1 : m_rot;
        tr = m_ccw ? m_rot - 2'd1 : m_rot + 2'd1;
        srs_lookup(m_idx, kr, i, kx, ky);
        if (m_ccw) begin
            kx = -kx;
            ky = -ky;
        end
        cx = POS_W'(int'(m_x) + kx);
        cy = POS_W'(int'(m_y) + ky);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic signed [POS_W-1:0] ex, ey;
        logic [1:0]              ekr, etr;
        if (!reset && check_req) begin
            model_cand(req_i, ex, ey, ekr, etr);
            chk("cand_x", int'(check_x), int'(ex));
            chk("cand_y", int'(check_y), int'(ey));
            chk("cand_rot", int'(check_rotation), int'(etr));
            chk("kick_rotation", int'(kick_rotation), int'(ekr));
            chk("kick_step", int'(kick_step), req_i);
            chk("kick_idx", int'(kick_idx), int'(m_idx));
        end
    end

    task automatic set_model(input logic [2:0] idx, input logic signed [POS_W-1:0] x,
                             input logic signed [POS_W-1:0] y, input logic [1:0] rot, input logic d);
        m_idx = idx;
        m_x   = x;
        m_y   = y;
        m_rot = rot;
        m_ccw = d & CCW_EN;
        req_i = 0;
        obs_x.delete();
        obs_kr.delete();
    endtask

    task automatic scramble_inputs();
        cur_x        = POS_W'($urandom);
        cur_y        = POS_W'($urandom);
        cur_rotation = 2'($urandom);
        cur_idx      = 3'($urandom);
        dir          = 1'($urandom);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 in IDLE after the done pulse.
    task automatic run_op(input logic [2:0] idx, input logic signed [POS_W-1:0] x,
                          input logic signed [POS_W-1:0] y, input logic [1:0] rot, input logic d,
                          input logic [4:0] hits, input int min_w, input int max_w, input bit poke);
        int n_tests, win, exp_n, nw;
        logic signed [POS_W-1:0] ex, ey;
        logic [1:0] ekr, etr;
        set_model(idx, x, y, rot, d);
        n_tests = (idx == P_O) ? 1 : MAX_STEP + 1;
        win = -1;
        for (int i = 0; i < n_tests; i++)
            if (!hits[i] && win < 0) win = i;
        exp_n = (win < 0) ? n_tests : win + 1;
        cur_x = x; cur_y = y; cur_rotation = rot; cur_idx = idx; dir = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        chk("busy_after_start", int'(busy), 1);
        for (int i = 0; i < exp_n; i++) begin
            nw = $urandom_range(max_w, min_w);
            for (int w = 0; w < nw; w++) begin
                if (poke && w == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("req_held", int'(check_req), 1);
                chk("no_early_done", int'(done), 0);
            end
            chk("req_high", int'(check_req), 1);
            obs_x.push_back(check_x);
            obs_kr.push_back(kick_rotation);
            check_ack = 1'b1;
            check_hit = hits[i];
            @(posedge clk); #1;
            check_ack = 1'b0;
            check_hit = 1'($urandom);
            req_i = i + 1;
        end
        if (win >= 0) begin
            model_cand(win, ex, ey, ekr, etr);
        end else begin
            ex = x; ey = y; etr = rot;
        end
        chk("done", int'(done), 1);
        chk("req_low_in_done", int'(check_req), 0);
        chk("success", int'(success), (win >= 0) ? 1 : 0);
        chk("new_x", int'(new_x), int'(ex));
        chk("new_y", int'(new_y), int'(ey));
        chk("new_rotation", int'(new_rotation), int'(etr));
        chk("kick_used", int'(kick_used), (win >= 0) ? win : 0);
        check_ack = 1'b1;
        @(posedge clk); #1;
        check_ack = 1'b0;
        chk("done_one_cycle", int'(done), 0);
        chk("busy_cleared", int'(busy), 0);
        chk("idle_no_req", int'(check_req), 0);
        chk("new_x_hold", int'(new_x), int'(ex));
        chk("success_hold", int'(success), (win >= 0) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dir = 1'b0; check_ack = 1'b0; check_hit = 1'b0;
        cur_x = '0; cur_y = '0; cur_rotation = '0; cur_idx = '0;
        set_model(P_T, '0, '0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_check_req", int'(check_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_success", int'(success), 0);
        chk("rst_new_x", int'(new_x), 0);
        chk("rst_new_y", int'(new_y), 0);
        chk("rst_new_rot", int'(new_rotation), 0);
        chk("rst_kick_used", int'(kick_used), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T piece, free at once: minimum latency
        run_op(P_T, 6'sd4, 6'sd10, 2'd0, 1'b0, 5'b00000, 0, 0, 1'b0);
        chk("t_lit_x", int'(new_x), 4);
        chk("t_lit_rot", int'(new_rotation), 1);
        chk("t_lit_reqs", obs_x.size(), 1);

        // I piece, free at test 2
        run_op(P_I, 6'sd4, 6'sd10, 2'd0, 1'b0, 5'b00011, 0, 2, 1'b0);
        chk("i_lit_reqs", obs_x.size(), 3);
        if (obs_x.size() == 3) begin
            chk("i_lit_x0", int'(obs_x[0]), 4);
            chk("i_lit_x1", int'(obs_x[1]), 2);
            chk("i_lit_x2", int'(obs_x[2]), 5);
        end
        chk("i_lit_new_x", int'(new_x), 5);
        chk("i_lit_kick", int'(kick_used), 2);

        // J piece, all tests hit
        run_op(P_J, 6'sd0, 6'sd5, 2'd3, 1'b0, 5'b11111, 0, 1, 1'b0);
        chk("j_lit_reqs", obs_x.size(), 5);
        chk("j_lit_success", int'(success), 0);
        chk("j_lit_new_y", int'(new_y), 5);
        chk("j_lit_rot", int'(new_rotation), 3);

        // O piece: one request only; start while busy is ignored
        run_op(P_O, 6'sd3, 6'sd7, 2'd2, 1'b0, 5'b11111, 1, 2, 1'b1);
        chk("o_lit_reqs", obs_x.size(), 1);
        @(posedge clk); #1;
        chk("o_no_restart", int'(busy), 0);

        // Signed wrap: x=31 plus +2 kick
        run_op(P_I, 6'sd31, -6'sd32, 2'd1, 1'b0, 5'b00011, 0, 0, 1'b0);
        chk("wrap_lit_x", int'(new_x), -31);

`ifdef ROTATE_CCW_EN
        run_op(P_T, 6'sd4, 6'sd10, 2'd1, 1'b1, 5'b00001, 0, 1, 1'b0);
        chk("ccw_lit_kick_rot", (obs_kr.size() > 0) ? int'(obs_kr[0]) : -1, 0);
        chk("ccw_lit_x1", (obs_x.size() > 1) ? int'(obs_x[1]) : -99, 5);
        chk("ccw_lit_rot", int'(new_rotation), 0);
        chk("ccw_lit_kick", int'(kick_used), 1);
`endif

        // Reset while a request is outstanding
        set_model(P_T, 6'sd3, 6'sd3, 2'd0, 1'b0);
        cur_x = 6'sd3; cur_y = 6'sd3; cur_rotation = 2'd0; cur_idx = P_T; dir = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_req", int'(check_req), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_req", int'(check_req), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_new_x", int'(new_x), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", int'(done), 0);
        end
        run_op(P_T, 6'sd4, 6'sd10, 2'd0, 1'b0, 5'b00000, 0, 0, 1'b0);

        // Randomized operations
        for (int n = 0; n < 80; n++) begin
            run_op(3'($urandom_range(6, 0)), POS_W'($urandom), POS_W'($urandom), 2'($urandom),
                   1'($urandom), 5'($urandom) | 5'($urandom), 0, 2, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
